// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths and queue entry type for the register write-back queue
package wb_pkg;

    localparam int WB_WORD_SIZE = 16;
    localparam int WB_REG_BITS  = 2;
    localparam int WB_DEPTH     = 4;

    // One queued register-file write: destination index plus value.
    typedef struct packed {
        logic [WB_REG_BITS-1:0]  rg;
        logic [WB_WORD_SIZE-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - circular 2-write/1-read entry store with pointer and occupancy tracking
module wb_fifo
    import wb_pkg::*;
#(
    parameter  int DEPTH = WB_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr0_en,
    input  wb_entry_t        wr0_entry,
    input  logic             wr1_en,
    input  wb_entry_t        wr1_entry,
    input  logic             rd_en,
    output wb_entry_t        head_entry,
    output logic [CNT_W-1:0] count,
    output logic [PTR_W-1:0] head_ptr,
    output wb_entry_t        entries [DEPTH]
);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    wb_entry_t        mem_q [DEPTH];

    // Next pointers/count; wr1 is only ever used together with wr0, so writes stay contiguous.
    always_comb begin
        tail_d  = tail_q + PTR_W'(wr0_en) + PTR_W'(wr1_en);
        head_d  = head_q + PTR_W'(rd_en);
        count_d = count_q + CNT_W'(wr0_en) + CNT_W'(wr1_en) - CNT_W'(rd_en);
    end

    // Pointer and occupancy registers; reset discards all queued entries.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset here.
    always_ff @(posedge clk) begin
        if (wr0_en) mem_q[tail_q] <= wr0_entry;
        if (wr1_en) mem_q[tail_q + PTR_W'(1)] <= wr1_entry;
    end

    assign head_entry = mem_q[head_q];
    assign count      = count_q;
    assign head_ptr   = head_q;
    assign entries    = mem_q;

endmodule

// File: rtl/reg_write_queue.sv
// rtl/reg_write_queue.sv - two-source register write-back queue with pending/forward lookup
module reg_write_queue
    import wb_pkg::*;
#(
    parameter  int WORD_SIZE = WB_WORD_SIZE,
    parameter  int REG_BITS  = WB_REG_BITS,
    parameter  int DEPTH     = WB_DEPTH,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 mem_valid,
    input  logic [REG_BITS-1:0]  mem_reg,
    input  logic [WORD_SIZE-1:0] mem_data,
    output logic                 mem_ready,
    input  logic                 alu_valid,
    input  logic [REG_BITS-1:0]  alu_reg,
    input  logic [WORD_SIZE-1:0] alu_data,
    output logic                 alu_ready,
    input  logic                 drain_en,
    output logic                 ctrlRegWrite,
    output logic [REG_BITS-1:0]  writeReg,
    output logic [WORD_SIZE-1:0] writeData,
    input  logic [REG_BITS-1:0]  query_reg1,
    input  logic [REG_BITS-1:0]  query_reg2,
    output logic                 pending1,
    output logic                 pending2,
    output logic [WORD_SIZE-1:0] fwd_data1,
    output logic [WORD_SIZE-1:0] fwd_data2,
    output logic [CNT_W-1:0]     count
);

    logic             mem_fire, alu_fire;
    logic             wr0_en, wr1_en, not_empty;
    wb_entry_t        mem_entry, alu_entry, wr0_entry, head_entry, slot;
    logic [PTR_W-1:0] head_ptr;
    wb_entry_t        entries [DEPTH];

    // Readies look only at the registered count and mem_valid; a same-cycle pop never frees a slot.
    always_comb begin
        mem_ready = reset_n && (count < CNT_W'(DEPTH));
        alu_ready = reset_n && (mem_valid ? (count < CNT_W'(DEPTH - 1)) : (count < CNT_W'(DEPTH)));
    end

    assign mem_entry = {mem_reg, mem_data};
    assign alu_entry = {alu_reg, alu_data};
    assign mem_fire  = mem_valid & mem_ready;
    assign alu_fire  = alu_valid & alu_ready;
    assign not_empty = (count != '0);

    // Memory result is older than a same-edge ALU result, so it takes the first slot.
    always_comb begin
        wr0_en    = mem_fire | alu_fire;
        wr0_entry = mem_fire ? mem_entry : alu_entry;
        wr1_en    = mem_fire & alu_fire;
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr0_en     (wr0_en),
        .wr0_entry  (wr0_entry),
        .wr1_en     (wr1_en),
        .wr1_entry  (alu_entry),
        .rd_en      (ctrlRegWrite),
        .head_entry (head_entry),
        .count      (count),
        .head_ptr   (head_ptr),
        .entries    (entries)
    );

    // Write port shows the head entry while occupied; zeros otherwise.
    always_comb begin
        ctrlRegWrite = reset_n && not_empty && drain_en;
        writeReg     = not_empty ? head_entry.rg   : '0;
        writeData    = not_empty ? head_entry.data : '0;
    end

    // Scan oldest to youngest so the last match seen is the youngest queued value.
    always_comb begin
        pending1  = 1'b0;
        pending2  = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        slot      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = entries[head_ptr + PTR_W'(i)];
            if (CNT_W'(i) < count) begin
                if (slot.rg == query_reg1) begin
                    pending1  = 1'b1;
                    fwd_data1 = slot.data;
                end
                if (slot.rg == query_reg2) begin
                    pending2  = 1'b1;
                    fwd_data2 = slot.data;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_write_queue.sv
// tb/tb_reg_write_queue.sv - scoreboard bench for reg_write_queue
module tb_reg_write_queue;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_valid, alu_valid, drain_en;
    logic [1:0]  mem_reg, alu_reg, query_reg1, query_reg2;
    logic [15:0] mem_data, alu_data;
    logic        mem_ready, alu_ready, ctrlRegWrite, pending1, pending2;
    logic [1:0]  writeReg;
    logic [15:0] writeData, fwd_data1, fwd_data2;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;
    int mcount = 0;
    logic [17:0] sb [$];

    always #5 clk = ~clk;

    reg_write_queue dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .mem_valid    (mem_valid),
        .mem_reg      (mem_reg),
        .mem_data     (mem_data),
        .mem_ready    (mem_ready),
        .alu_valid    (alu_valid),
        .alu_reg      (alu_reg),
        .alu_data     (alu_data),
        .alu_ready    (alu_ready),
        .drain_en     (drain_en),
        .ctrlRegWrite (ctrlRegWrite),
        .writeReg     (writeReg),
        .writeData    (writeData),
        .query_reg1   (query_reg1),
        .query_reg2   (query_reg2),
        .pending1     (pending1),
        .pending2     (pending2),
        .fwd_data1    (fwd_data1),
        .fwd_data2    (fwd_data2),
        .count        (count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic mv, input logic [1:0] mr, input logic [15:0] md,
                         input logic av, input logic [1:0] ar, input logic [15:0] ad,
                         input logic de);
        mem_valid = mv; mem_reg = mr; mem_data = md;
        alu_valid = av; alu_reg = ar; alu_data = ad;
        drain_en  = de;
    endtask

    // One clock: check outputs mid-cycle against the scoreboard, then step past the edge.
    task automatic cycle();
        logic exp_mr, exp_ar, mf, af, pop, ep1, ep2;
        logic [15:0] ef1, ef2;
        @(negedge clk);
        check("count", count, mcount);
        if (!reset_n) begin
            check("mem_ready_rst", mem_ready, 0);
            check("alu_ready_rst", alu_ready, 0);
            check("wr_rst", ctrlRegWrite, 0);
        end else begin
            exp_mr = (mcount < 4);
            exp_ar = mem_valid ? (mcount < 3) : (mcount < 4);
            check("mem_ready", mem_ready, exp_mr);
            check("alu_ready", alu_ready, exp_ar);
            ep1 = 0; ep2 = 0; ef1 = 0; ef2 = 0;
            for (int i = 0; i < sb.size(); i++) begin
                if (sb[i][17:16] == query_reg1) begin ep1 = 1; ef1 = sb[i][15:0]; end
                if (sb[i][17:16] == query_reg2) begin ep2 = 1; ef2 = sb[i][15:0]; end
            end
            check("pending1", pending1, ep1);
            check("fwd_data1", fwd_data1, ef1);
            check("pending2", pending2, ep2);
            check("fwd_data2", fwd_data2, ef2);
            pop = (mcount != 0) && drain_en;
            check("ctrlRegWrite", ctrlRegWrite, pop);
            if (pop && sb.size() > 0) begin
                check("writeReg", writeReg, sb[0][17:16]);
                check("writeData", writeData, sb[0][15:0]);
                void'(sb.pop_front());
            end else if (mcount == 0) begin
                check("writeReg_empty", writeReg, 0);
                check("writeData_empty", writeData, 0);
            end
            mf = mem_valid && exp_mr;
            af = alu_valid && exp_ar;
            if (mf) sb.push_back({mem_reg, mem_data});
            if (af) sb.push_back({alu_reg, alu_data});
            mcount = mcount + int'(mf) + int'(af) - int'(pop);
        end
        @(posedge clk);
        #1;
        if (!reset_n) begin
            sb.delete();
            mcount = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        query_reg1 = 2'd1;
        query_reg2 = 2'd2;
        drive(0, 0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        reset_n = 1'b1;

        // single memory write, one-cycle latency
        drive(1, 2'd2, 16'h1234, 0, 0, 0, 1);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 1);
        cycle();
        cycle();

        // both sources at once: memory older, ALU value forwarded
        drive(1, 2'd1, 16'hAAAA, 1, 2'd1, 16'hBBBB, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 1);
        repeat (3) cycle();

        // fill to three, then both offered: only memory fits; full blocks both even while draining
        drive(1, 2'd0, 16'h0001, 1, 2'd3, 16'h0002, 0);
        cycle();
        drive(1, 2'd2, 16'h0003, 0, 0, 0, 0);
        cycle();
        drive(1, 2'd1, 16'h0004, 1, 2'd2, 16'h0005, 0);
        cycle();
        drive(1, 2'd1, 16'h0006, 1, 2'd2, 16'h0007, 1);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 1);
        repeat (5) cycle();

        // fill to four, then drain while the ALU streams: pointer wrap
        drive(1, 2'd0, 16'h0010, 1, 2'd1, 16'h0011, 0);
        cycle();
        drive(1, 2'd2, 16'h0012, 1, 2'd3, 16'h0013, 0);
        cycle();
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, 0, 1, 2'(k), 16'h0100 + 16'(k), 1);
            query_reg1 = 2'(k);
            cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        repeat (6) cycle();

        // reset with three queued: nothing stale may be written afterwards
        drive(1, 2'd3, 16'h0DEAD & 16'hFFFF, 1, 2'd3, 16'hBEEF, 0);
        cycle();
        drive(1, 2'd1, 16'hCAFE, 0, 0, 0, 0);
        cycle();
        reset_n = 1'b0;
        drive(1, 2'd0, 16'h5555, 1, 2'd0, 16'h6666, 1);
        cycle();
        reset_n = 1'b1;
        query_reg1 = 2'd3;
        query_reg2 = 2'd1;
        drive(0, 0, 0, 0, 0, 0, 1);
        repeat (3) cycle();

        // random traffic
        for (int k = 0; k < 300; k++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom), 16'($urandom),
                  1'($urandom_range(0, 1)), 2'($urandom), 16'($urandom),
                  1'($urandom_range(0, 2) != 0));
            query_reg1 = 2'($urandom);
            query_reg2 = 2'($urandom);
            cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        repeat (6) cycle();
        check("sb_empty", 32'(sb.size()), 0);
        check("count_final", count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_write_queue.md
REG_WRITE_QUEUE -- requirements
Module: reg_write_queue

Interface
REQ-001 Parameters SHALL be: WORD_SIZE, 16, data width; REG_BITS, 2, register index width (4 registers); DEPTH, 4, queue entries (power of two).
REQ-002 Clock and reset SHALL be: clk in 1, clock; reset_n in 1, reset, synchronous, active-low.
REQ-003 Memory source port SHALL be: mem_valid in 1, load result offered; mem_reg in REG_BITS, destination; mem_data in WORD_SIZE, value; mem_ready out 1, offer accepted this edge.
REQ-004 ALU source port SHALL be: alu_valid in 1; alu_reg in REG_BITS; alu_data in WORD_SIZE; alu_ready out 1; same meanings as the memory port.
REQ-005 Drain control SHALL be: drain_en in 1, register-file write port available this cycle.
REQ-006 Register-file write port SHALL be: ctrlRegWrite out 1, write strobe; writeReg out REG_BITS, destination; writeData out WORD_SIZE, value.
REQ-007 Pending-query ports SHALL be: query_reg1/query_reg2 in REG_BITS; pending1/pending2 out 1, queued write exists; fwd_data1/fwd_data2 out WORD_SIZE, youngest queued value.
REQ-008 Status SHALL be: count out 3, occupied entries 0..DEPTH.

Function
REQ-009 Storage SHALL be a circular FIFO of DEPTH {reg,data} entries with head/tail pointers wrapping modulo DEPTH and a registered occupancy count.
REQ-010 Transfer on a source port SHALL occur on a rising edge where valid and ready are both 1; valid without ready SHALL leave the offer held by the source, nothing enqueued.
REQ-011 mem_ready SHALL be 1 iff count < DEPTH; memory has priority.
REQ-012 alu_ready SHALL be 1 iff count < DEPTH-1 when mem_valid=1, else iff count < DEPTH.
REQ-013 Readies SHALL depend only on registered count and mem_valid, never on drain_en or a same-cycle pop; full queue deasserts both readies even while draining.
REQ-014 Both sources accepted on one edge SHALL enqueue memory entry first (older), ALU entry second.
REQ-015 ctrlRegWrite SHALL equal (count != 0) and drain_en; writeReg/writeData SHALL present the head entry combinationally, 0 when empty.
REQ-016 Each edge with ctrlRegWrite=1 SHALL pop the head; at most one pop per cycle.
REQ-017 Minimum latency SHALL be one cycle: entry accepted at edge N is visible on the write port in cycle N+1 if the queue was empty.
REQ-018 count update SHALL be count + pushes - pop, with pushes in {0,1,2}, simultaneous push and pop handled in the same edge.
REQ-019 pendingN SHALL be 1 iff any occupied entry, head included, has reg == query_regN; fwd_dataN SHALL be the data of the youngest matching entry, 0 when none.
REQ-020 Register-file writes SHALL retire strictly in enqueue order; multiple queued writes to one register SHALL all be issued.

Reset
REQ-021 On an edge with reset_n=0: head, tail, count SHALL clear to 0; entry contents need not be cleared.
REQ-022 While reset_n=0, ctrlRegWrite, mem_ready, alu_ready SHALL be 0; pending1/2 and fwd_data1/2 SHALL be 0 in the cycle after the reset edge.
REQ-023 Reset mid-operation SHALL discard all queued entries with no write issued after the reset edge.

Structure
REQ-024 WORD_SIZE, REG_BITS, DEPTH defaults and the {reg,data} entry typedef SHALL live in shared package wb_pkg.
REQ-025 Storage and pointer logic SHALL be sub-module wb_fifo (2-write/1-read, with entry-array read-out for the query match); arbitration and query logic stay in reg_write_queue.

Verification
REQ-026 Empty queue, mem (reg 2, 0x1234) accepted at edge 1, drain_en=1 -> cycle 2 ctrlRegWrite=1, writeReg=2, writeData=0x1234; count 0 after edge 2.
REQ-027 Both valid at count=0: mem (1,0xAAAA), alu (1,0xBBBB), drain_en=0 -> count=2; pending1=1 for query_reg1=1, fwd_data1=0xBBBB; drain order 0xAAAA then 0xBBBB.
REQ-028 count=3, both valid -> mem_ready=1, alu_ready=0; after edge count=4, both readies 0 even with drain_en=1.
REQ-029 Fill to 4, drain_en=1 and alu_valid=1 for 8 cycles -> pointers wrap, 8 writes in exact enqueue order, no loss or duplication.
REQ-030 count=3, reset_n=0 for one edge -> count=0, ctrlRegWrite=0, pending1=pending2=0; no stale entry ever written.
